// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the bubble/NOP control
// encoding and an example per-stage control layout that stages pack into
// their opaque in_ctrl bundle.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 48;
    localparam int unsigned CNT_W_DEF  = 16;

    // Control value presented for an empty or bubble slot.
    localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

    // Example ID/EX control layout (32 bits), packed by the stage owner.
    typedef struct packed {
        logic [7:0] opcode;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [5:0] rsvd;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for debug performance counters.
// Ports: clk, rst_n (sync, active-low), inc (count enable), count (value).
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment unless already at all-ones; never wraps.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a main slot and a one-entry
// skid slot, flush, bubble insertion, sticky halt freeze and saturating
// stall/bubble counters.
// Ports: clk, rst_n (sync, active-low); flush, insert_nop control;
// in_valid/in_ready/in_ctrl/in_data/in_hlt upstream handshake;
// out_valid/out_ready/out_ctrl/out_data/out_hlt downstream handshake;
// halted status; stall_cnt/bubble_cnt debug counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = CTRL_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(NOP_CTRL),
    parameter int unsigned       CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              insert_nop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_hlt,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              main_hlt_q,   main_hlt_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              skid_hlt_q,   skid_hlt_d;
    logic              halted_q,     halted_d;

    logic main_free;
    logic accept;
    logic stall_inc;
    logic bubble_inc;

    // Only flush, insert_nop and reset act combinationally on in_ready.
    assign in_ready  = rst_n & ~skid_valid_q & ~halted_q & ~flush & ~insert_nop;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid_q | out_ready;
    assign stall_inc = main_valid_q & ~out_ready & ~halted_q & ~flush;

    // Next-state for both slots and halt, in priority flush > halt > nop > normal.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_hlt_d   = main_hlt_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_hlt_d   = skid_hlt_q;
        halted_d     = halted_q;
        bubble_inc   = 1'b0;

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = BUBBLE_CTRL;
            main_data_d  = '0;
            main_hlt_d   = 1'b0;
            skid_valid_d = 1'b0;
            halted_d     = 1'b0;
        end else if (halted_q) begin
            // Frozen: hold everything.
        end else if (insert_nop) begin
            // Bubble only replaces a free main slot; skid stays put.
            if (main_free) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = BUBBLE_CTRL;
                main_data_d  = '0;
                main_hlt_d   = 1'b0;
                bubble_inc   = 1'b1;
            end
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                main_hlt_d   = skid_hlt_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
                main_hlt_d   = in_hlt;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = BUBBLE_CTRL;
                main_data_d  = '0;
                main_hlt_d   = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
            skid_hlt_d   = in_hlt;
        end

        // Freeze as soon as a halt entry occupies the main slot.
        if (!flush && main_valid_d && main_hlt_d) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= BUBBLE_CTRL;
            main_data_q  <= '0;
            main_hlt_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_hlt_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_hlt_q   <= main_hlt_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_hlt_q   <= skid_hlt_d;
            halted_q     <= halted_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign out_hlt   = main_hlt_q;
    assign halted    = halted_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule
